// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared encodings for the sequential multiply/divide unit.
//             op[0] selects MULT (OP_MULT) or DIV (OP_DIV). op[1] == OP_UNS
//             selects unsigned operation when MULDIV_UNSIGNED_EN is defined.
//             It also holds the controller state enum and the default
//             operand width.
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int   DEFAULT_WIDTH = 32;

    // op[0] values
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;
    // op[1] value that requests unsigned arithmetic
    localparam logic OP_UNS  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_negate.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_negate
//  Purpose  : Combinational conditional two's complement, y = neg ? -x : x.
//             It forms operand magnitudes and applies the result sign fix-up.
//  Ports    : x   [WIDTH-1:0]  value in
//             neg              1 = negate
//             y   [WIDTH-1:0]  value out
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_negate
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? ((~x) + WIDTH'(1)) : x;

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Sequential HI/LO multiply/divide unit. It performs a radix-2
//             Booth multiply or a restoring divide over WIDTH iterations.
//             It uses a start/busy/done handshake.
//             Optional macro MULDIV_UNSIGNED_EN: when defined, op[1]=1
//             selects unsigned MULTU/DIVU. When it is undefined, op[1] is
//             ignored and all ops are signed.
//  Ports    : clk, reset_n (async, active-low)
//             start, op[1:0], data_a, data_b  - request and operands
//             busy, done (1-cycle pulse)      - handshake
//             out_high (prod hi / remainder), out_low (prod lo / quotient)
//             div_zero                        - last DIV had divisor 0
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_high,
    output logic [WIDTH-1:0] out_low,
    output logic             div_zero
);

    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   acc;      // Booth A / restoring partial remainder
    logic [WIDTH:0]   mcand;    // extended multiplicand / zero-extended |divisor|
    logic [WIDTH-1:0] qreg;     // multiplier / dividend shifting into quotient
    logic             q_m1;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             req_div;
    logic             req_uns;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH+1:0] booth_sum;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH+1:0] div_diff;
    logic             div_ge;
    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [WIDTH-1:0] mult_hi;
    logic [WIDTH-1:0] hi_raw;
    logic [WIDTH-1:0] hi_fix;
    logic [WIDTH-1:0] lo_fix;

    assign accept    = start & ~busy;
    assign req_div   = (op[0] == OP_DIV);
    assign a_neg     = ~req_uns & data_a[WIDTH-1];
    assign b_neg     = ~req_uns & data_b[WIDTH-1];
    assign count_nxt = count + CNT_W'(1);

    muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (.x(data_a), .neg(a_neg), .y(mag_a));
    muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (.x(data_b), .neg(b_neg), .y(mag_b));

    // One iteration of either algorithm. The final edge writes the outputs
    // from these next-state values, so no intermediate result is ever visible.
    always_comb begin
        // Booth add/sub is done one bit wider than A. An unsigned multiplicand
        // near 2^W would otherwise overflow before the arithmetic shift.
        booth_sum = {acc[WIDTH], acc};
        case ({qreg[0], q_m1})
            2'b01:   booth_sum = {acc[WIDTH], acc} + {mcand[WIDTH], mcand};
            2'b10:   booth_sum = {acc[WIDTH], acc} - {mcand[WIDTH], mcand};
            default: ;
        endcase

        div_rem  = {acc[WIDTH-1:0], qreg[WIDTH-1]};
        div_diff = {1'b0, div_rem} - {1'b0, mcand};
        div_ge   = ~div_diff[WIDTH+1];

        if (is_div) begin
            acc_nxt = div_ge ? div_diff[WIDTH:0] : div_rem;
            q_nxt   = {qreg[WIDTH-2:0], div_ge};
        end else begin
            acc_nxt = booth_sum[WIDTH+1:1];
            q_nxt   = {booth_sum[0], qreg[WIDTH-1:1]};
        end
    end

`ifdef MULDIV_UNSIGNED_EN
    logic is_uns;

    assign req_uns = (op[1] == OP_UNS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_uns <= 1'b0;
        end else if (accept) begin
            is_uns <= req_uns;
        end
    end

    // The zero-extended multiplier has one more Booth step, with pair
    // (0, b[W-1]). It can only add the multiplicand into the high half, so it
    // is folded into the final edge. qreg[0] holds b[W-1] on that edge.
    assign mult_hi = acc_nxt[WIDTH-1:0] + ((is_uns && qreg[0]) ? mcand[WIDTH-1:0] : '0);
`else
    logic unused_op_uns;

    assign req_uns       = 1'b0;
    assign unused_op_uns = op[1];
    assign mult_hi       = acc_nxt[WIDTH-1:0];
`endif

    assign hi_raw = is_div ? acc_nxt[WIDTH-1:0] : mult_hi;

    // neg_q/neg_r are only ever set for DIV, so MULT passes straight through.
    muldiv_negate #(.WIDTH(WIDTH)) u_fix_lo (.x(q_nxt),  .neg(neg_q), .y(lo_fix));
    muldiv_negate #(.WIDTH(WIDTH)) u_fix_hi (.x(hi_raw), .neg(neg_r), .y(hi_fix));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_high <= '0;
            out_low  <= '0;
            div_zero <= 1'b0;
            count    <= '0;
            acc      <= '0;
            mcand    <= '0;
            qreg     <= '0;
            q_m1     <= 1'b0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy     <= 1'b1;
                count    <= '0;
                acc      <= '0;
                q_m1     <= 1'b0;
                is_div   <= req_div;
                neg_q    <= req_div & (a_neg ^ b_neg);
                neg_r    <= req_div & a_neg;
                div_zero <= req_div & (data_b == '0);
                if (op[0] == OP_MULT) begin
                    qreg  <= data_b;
                    mcand <= {a_neg, data_a};
                    state <= RUN;
                end else if (data_b == '0) begin
                    // Divide-by-zero skips RUN. The raw dividend is parked in
                    // qreg and becomes out_high on the next edge.
                    qreg  <= data_a;
                    state <= DONE;
                end else begin
                    qreg  <= mag_a;
                    mcand <= {1'b0, mag_b};
                    state <= RUN;
                end
            end else begin
                case (state)
                    RUN: begin
                        acc   <= acc_nxt;
                        qreg  <= q_nxt;
                        q_m1  <= qreg[0];
                        count <= count_nxt;
                        if (count_nxt == CNT_LAST) begin
                            out_high <= hi_fix;
                            out_low  <= lo_fix;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE: begin
                        // busy still set here means a divide-by-zero completion
                        if (busy) begin
                            out_high <= qreg;
                            out_low  <= '1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
